// File: rtl/fifo_arb_pkg_amisha.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg_amisha
// Shared definitions for the two-requester FIFO write arbiter:
//   - state_t     : FSM encoding (IDLE=0, WRITE=1)
//   - DATA_W_DEF  : default write-data width
//   - CNT_W       : width of the accepted-write counters
//   - pick_winner : round-robin choice between the two requesters
// ---------------------------------------------------------------------------
package fifo_arb_pkg_amisha;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    // A lone request wins outright; a tie goes to whoever did not win last.
    function automatic logic pick_winner(input logic req0,
                                         input logic req1,
                                         input logic last_grant);
        if (req0 && req1) return ~last_grant;
        return req1;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_amisha.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb_amisha
// Arbitrates two write requesters onto one external FIFO write port.
// IDLE samples the requests and the FIFO full flag; a grant latches the
// winner's data and spends exactly one cycle in WRITE driving the strobe,
// data and the winner's ack, then returns to IDLE. One write per two cycles
// at most, so full is always re-evaluated after the previous write lands.
//
// Ports:
//   clk_amisha, reset_amisha (async, active low)
//   req0/req1_amisha, data0/data1_amisha : requester inputs
//   ack0/ack1_amisha                     : one-cycle accept pulses
//   full_amisha                          : FIFO full flag (input)
//   wr_amisha, w_data_amisha             : FIFO write strobe / data
//   busy_amisha                          : high while in WRITE
//   cnt0/cnt1_amisha                     : accepted-write counts
//
// Optional feature: define FIFO_ARB_CNT_EN to enable the saturating
// accepted-write counters; otherwise the counter outputs are tied to zero.
// ---------------------------------------------------------------------------
module fifo_wr_arb_amisha
    import fifo_arb_pkg_amisha::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_amisha,
    input  logic              reset_amisha,
    input  logic              req0_amisha,
    input  logic              req1_amisha,
    input  logic [DATA_W-1:0] data0_amisha,
    input  logic [DATA_W-1:0] data1_amisha,
    output logic              ack0_amisha,
    output logic              ack1_amisha,
    input  logic              full_amisha,
    output logic              wr_amisha,
    output logic [DATA_W-1:0] w_data_amisha,
    output logic              busy_amisha,
    output logic [CNT_W-1:0]  cnt0_amisha,
    output logic [CNT_W-1:0]  cnt1_amisha
);

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_hold;
    logic                r_last_grant;
    logic                w_win;
    logic                w_start;

    assign w_win   = pick_winner(req0_amisha, req1_amisha, r_last_grant);
    assign w_start = (r_state == ST_IDLE) && (req0_amisha || req1_amisha)
                     && !full_amisha;

    always_ff @(posedge clk_amisha or negedge reset_amisha) begin
        if (!reset_amisha) begin
            r_state      <= ST_IDLE;
            r_hold       <= '0;
            r_last_grant <= 1'b1;   // requester 0 wins the first tie
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_hold       <= w_win ? data1_amisha : data0_amisha;
                r_last_grant <= w_win;
            end
        end
    end

    // Holding register only changes on a grant, so the write data keeps its
    // last value through IDLE.
    assign w_data_amisha = r_hold;

    // Outputs decode from the state register alone, so an asynchronous reset
    // drops them the instant it asserts.
    always_comb begin
        w_next      = r_state;
        wr_amisha   = 1'b0;
        ack0_amisha = 1'b0;
        ack1_amisha = 1'b0;
        busy_amisha = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                wr_amisha   = 1'b1;
                busy_amisha = 1'b1;
                ack0_amisha = ~r_last_grant;
                ack1_amisha = r_last_grant;
                w_next      = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

`ifdef FIFO_ARB_CNT_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    always_ff @(posedge clk_amisha or negedge reset_amisha) begin
        if (!reset_amisha) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (ack0_amisha && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + CNT_W'(1);
            if (ack1_amisha && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + CNT_W'(1);
        end
    end

    assign cnt0_amisha = r_cnt0;
    assign cnt1_amisha = r_cnt1;
`else
    assign cnt0_amisha = '0;
    assign cnt1_amisha = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb_amisha.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arb_amisha
// Scoreboard bench for fifo_wr_arb_amisha: every expected FIFO write is
// queued when its stimulus is driven and popped by the negedge monitor when
// the DUT strobes wr. A reference round-robin pointer predicts tie winners.
// Counter checks depend on FIFO_ARB_CNT_EN.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arb_amisha;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, full;
    logic [DW-1:0] d0, d1;
    logic          ack0, ack1, wr, busy;
    logic [DW-1:0] w_data;
    logic [15:0]   cnt0, cnt1;

    always #5 clk = ~clk;

    fifo_wr_arb_amisha #(.DATA_W(DW)) dut (
        .clk_amisha    (clk),
        .reset_amisha  (rst_n),
        .req0_amisha   (req0),
        .req1_amisha   (req1),
        .data0_amisha  (d0),
        .data1_amisha  (d1),
        .ack0_amisha   (ack0),
        .ack1_amisha   (ack1),
        .full_amisha   (full),
        .wr_amisha     (wr),
        .w_data_amisha (w_data),
        .busy_amisha   (busy),
        .cnt0_amisha   (cnt0),
        .cnt1_amisha   (cnt1)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          who;
    } exp_t;

    exp_t sb[$];
    int   vecs = 0;
    int   errs = 0;
    logic lg;   // reference last-grant pointer

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each write.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("ack_excl", {31'b0, ack0 & ack1}, 32'd0);
            chk("busy_eq_wr", {31'b0, busy}, {31'b0, wr});
            if (wr === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexp_wr", {31'b0, wr}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wdata", {24'b0, w_data}, {24'b0, e.d});
                    chk("ack0", {31'b0, ack0}, {31'b0, ~e.who});
                    chk("ack1", {31'b0, ack1}, {31'b0, e.who});
                end
            end
        end
    end

    task automatic push(input logic [DW-1:0] d, input logic who);
        exp_t e;
        e.d   = d;
        e.who = who;
        sb.push_back(e);
    endtask

    // Advance n cycles; optionally drop a request once its ack is seen.
    task automatic run_cycles(input int n, input bit drop);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (drop) begin
                if (ack0) req0 = 1'b0;
                if (ack1) req1 = 1'b0;
            end
        end
    endtask

    task automatic drain(input string tag);
        chk(tag, sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        full  = 1'b0;
        lg    = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic one_write(input logic who, input logic [DW-1:0] d);
        if (who) begin d1 = d; req1 = 1'b1; end
        else     begin d0 = d; req0 = 1'b1; end
        push(d, who);
        lg = who;
        run_cycles(4, 1'b1);
        drain("one_drain");
    endtask

    initial begin
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        full  = 1'b0;
        d0    = '0;
        d1    = '0;
        lg    = 1'b1;

        // Reset state
        #12;
        chk("rst_wr",    {31'b0, wr},    32'd0);
        chk("rst_ack0",  {31'b0, ack0},  32'd0);
        chk("rst_ack1",  {31'b0, ack1},  32'd0);
        chk("rst_busy",  {31'b0, busy},  32'd0);
        chk("rst_wdata", {24'b0, w_data}, 32'd0);
        chk("rst_cnt0",  {16'b0, cnt0},  32'd0);
        chk("rst_cnt1",  {16'b0, cnt1},  32'd0);
        do_reset();

        // Single request: write lands one cycle after the sampling edge
        d0 = 8'hBB; req0 = 1'b1;
        push(8'hBB, 1'b0);
        @(posedge clk); #1;
        chk("single_wr",   {31'b0, wr},   32'd1);
        chk("single_ack0", {31'b0, ack0}, 32'd1);
        chk("single_data", {24'b0, w_data}, 32'h0BB);
        req0 = 1'b0;
        @(posedge clk); #1;
        chk("single_idle", {31'b0, busy}, 32'd0);
        chk("single_hold", {24'b0, w_data}, 32'h0BB);
        run_cycles(2, 1'b0);
        drain("single_drain");

        // Tie held high after reset: 0,1,0
        do_reset();
        d0 = 8'hA3; d1 = 8'hFF; req0 = 1'b1; req1 = 1'b1;
        push(8'hA3, 1'b0);
        push(8'hFF, 1'b1);
        push(8'hA3, 1'b0);
        run_cycles(6, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        run_cycles(2, 1'b0);
        drain("tie_drain");

        // Full blocks the request; write follows once full drops
        do_reset();
        full = 1'b1; d1 = 8'h5C; req1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("full_nowr",  {31'b0, wr},   32'd0);
            chk("full_noack", {31'b0, ack1}, 32'd0);
        end
        full = 1'b0;
        push(8'h5C, 1'b1);
        @(posedge clk); #1;
        chk("full_wr",   {31'b0, wr},   32'd1);
        chk("full_ack1", {31'b0, ack1}, 32'd1);
        req1 = 1'b0;
        run_cycles(2, 1'b0);
        drain("full_drain");

        // Reset mid-WRITE: outputs drop immediately, nothing written after
        do_reset();
        d0 = 8'h77; req0 = 1'b1;
        @(posedge clk); #1;
        chk("mid_inwrite", {31'b0, wr}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_wr",    {31'b0, wr},   32'd0);
        chk("mid_ack0",  {31'b0, ack0}, 32'd0);
        chk("mid_busy",  {31'b0, busy}, 32'd0);
        chk("mid_wdata", {24'b0, w_data}, 32'd0);
        req0 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        lg = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_rst_nowr", {31'b0, wr}, 32'd0);
        end
        drain("mid_drain");

        // Random traffic against the reference round-robin pointer
        do_reset();
        for (int r = 0; r < 10; r++) begin
            int pat;
            logic w;
            pat = $urandom_range(1, 3);
            d0  = DW'($urandom);
            d1  = DW'($urandom);
            if (pat == 1) begin
                push(d0, 1'b0); lg = 1'b0;
            end else if (pat == 2) begin
                push(d1, 1'b1); lg = 1'b1;
            end else begin
                w = ~lg;
                push(w ? d1 : d0, w);
                push(w ? d0 : d1, ~w);
                lg = ~w;
            end
            req0 = pat[0];
            req1 = pat[1];
            run_cycles(6, 1'b1);
            req0 = 1'b0; req1 = 1'b0;
            drain("rand_drain");
        end

        // Counters
        do_reset();
        one_write(1'b0, 8'h11);
        one_write(1'b0, 8'h22);
        one_write(1'b0, 8'h33);
`ifdef FIFO_ARB_CNT_EN
        chk("cnt0_three", {16'b0, cnt0}, 32'd3);
        chk("cnt1_zero",  {16'b0, cnt1}, 32'd0);
        dut.r_cnt1 = 16'hFFFE;
        one_write(1'b1, 8'h44);
        chk("cnt1_top", {16'b0, cnt1}, 32'h0FFFF);
        one_write(1'b1, 8'h55);
        chk("cnt1_sat", {16'b0, cnt1}, 32'h0FFFF);
        chk("cnt0_kept", {16'b0, cnt0}, 32'd3);
`else
        one_write(1'b1, 8'h44);
        chk("cnt0_off", {16'b0, cnt0}, 32'd0);
        chk("cnt1_off", {16'b0, cnt1}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb_amisha.md
FIFO_WR_ARB_AMISHA -- requirements
Module: fifo_wr_arb_amisha

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the write-data width.
REQ-002 SHALL have port clk_amisha, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_amisha, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports req0_amisha and req1_amisha, input, 1 each, write requests from requesters 0 and 1.
REQ-005 SHALL have ports data0_amisha and data1_amisha, input, DATA_W each, request data.
REQ-006 SHALL have ports ack0_amisha and ack1_amisha, output, 1 each, one-cycle accept pulses.
REQ-007 SHALL have port full_amisha, input, 1, the full flag from the shared FIFO.
REQ-008 SHALL have port wr_amisha, output, 1, the FIFO write strobe.
REQ-009 SHALL have port w_data_amisha, output, DATA_W, the FIFO write data.
REQ-010 SHALL have port busy_amisha, output, 1, high while in WRITE.
REQ-011 SHALL have ports cnt0_amisha and cnt1_amisha, output, 16 each, accepted-write counts.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and WRITE.
REQ-013 SHALL, in IDLE, move to WRITE when at least one request is high and full_amisha is low; otherwise it SHALL stay in IDLE.
REQ-014 SHALL, on the IDLE->WRITE edge, latch the winner's data into a holding register and record the winner in last_grant.
REQ-015 SHALL pick the only active requester when one request is high; when both are high, it SHALL pick the requester that is not last_grant (round-robin).
REQ-016 SHALL, in WRITE, drive wr_amisha=1, w_data_amisha=holding register, the winner's ack=1 and busy_amisha=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-017 SHALL drive wr_amisha=0, both acks=0 and busy_amisha=0 in IDLE; w_data_amisha holds its last value.
REQ-018 SHALL give a latency of one cycle from the sampling edge to the wr_amisha assertion; maximum throughput is one write per two cycles, so full_amisha is always evaluated after the previous write has landed.
REQ-019 SHALL never assert wr_amisha for a decision made while full_amisha was high; no write is ever issued into a full FIFO.
REQ-020 SHALL expect requesters to hold req and data stable until ack and to drop req on the edge after ack; a req still high in IDLE is treated as a new request.
REQ-021 SHALL ignore changes to req, data or full_amisha during WRITE; the latched write completes.
REQ-022 SHALL never assert ack0_amisha and ack1_amisha together.

Reset
REQ-023 SHALL, while reset_amisha=0, immediately force IDLE, wr_amisha=0, w_data_amisha=0, ack0/ack1=0, busy_amisha=0, cnt0/cnt1=0 and last_grant=1 (requester 0 wins the first tie).
REQ-024 SHALL discard an in-flight WRITE when reset asserts mid-operation, with no write strobe issued.

Configuration
REQ-025 SHALL, when macro FIFO_ARB_CNT_EN is defined, increment cnt0_amisha or cnt1_amisha by one on each ack of that requester, saturating at 16'hFFFF.
REQ-026 SHALL, when FIFO_ARB_CNT_EN is undefined, tie cnt0_amisha and cnt1_amisha to 0 with no counter flops; port list unchanged.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE=0, WRITE=1), the DATA_W default and the counter width (16) in shared package fifo_arb_pkg_amisha.
REQ-028 SHALL be a single module with no sub-module; it instantiates no FIFO, and the FIFO connects externally via wr/w_data/full.

Verification
REQ-029 SHALL test a single request: req0=1, data0=8'hBB, full=0 -> wr=1 with w_data=8'hBB and ack0=1 one cycle after sampling, then IDLE.
REQ-030 SHALL test a tie: req0=req1=1 held, data0=8'hA3, data1=8'hFF, after reset -> writes 8'hA3, 8'hFF, 8'hA3 on alternating WRITE cycles, with acks alternating 0,1,0.
REQ-031 SHALL test full: full=1 with req1=1 -> no wr and no ack for 5 cycles; full drops -> wr=1 on the next WRITE cycle with ack1 asserted.
REQ-032 SHALL test reset mid-WRITE: reset_amisha=0 asynchronously during WRITE -> wr, ack and busy deassert immediately; after release with no requests, no write occurs.
REQ-033 SHALL test the counters with FIFO_ARB_CNT_EN defined: 3 acks to requester 0 -> cnt0=3, cnt1=0; a counter preloaded near 16'hFFFF stays at 16'hFFFF; with the macro undefined, both counters read 0.
